sparse_act_decoder: RTL and testbench

// - Receive-side counterpart of the output compressor: rebuilds dense activation words from a mask

---
 rtl/sparse_act_decoder.sv | 151 +++++++++++++++
 tb/tb_sparse_act_decoder.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_act_decoder.sv
// sparse_act_decoder: rebuilds dense activation words from a lane-mask stream
// and a packed stream of nonzero bytes (receive side of the output compressor).
// Optional build macro: SPARSE_DEC_STATS_EN adds the saturating zero_count port.

module sparse_act_decoder #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MEM_BW     = 128,
  localparam int unsigned LANES      = MEM_BW / DATA_WIDTH
) (
  input  logic              clk,
  input  logic              arst_n_in,
  input  logic              clear,
  input  logic [LANES-1:0]  masks_input,
  input  logic              masks_valid,
  output logic              masks_ready,
  input  logic [MEM_BW-1:0] encoded_input,
  input  logic              encoded_valid,
  output logic              encoded_ready,
  output logic [MEM_BW-1:0] dense_out,
  output logic              dense_valid,
  input  logic              dense_ready
`ifdef SPARSE_DEC_STATS_EN
  ,
  output logic [31:0]       zero_count
`endif
);

  localparam int unsigned BUF_BYTES = 2 * LANES;
  localparam int unsigned CNT_W     = $clog2(BUF_BYTES + 1);
  localparam int unsigned IDX_W     = $clog2(BUF_BYTES);
  localparam int unsigned POP_W     = $clog2(LANES + 1);

  logic [DATA_WIDTH-1:0] buf_q [BUF_BYTES];
  logic [DATA_WIDTH-1:0] buf_d [BUF_BYTES];
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W-1:0]      rem;
  logic [LANES-1:0]      mask_q;
  logic                  mask_full;
  logic [POP_W-1:0]      pop;
  logic [POP_W-1:0]      pop_used;
  logic                  dec_fire;
  logic                  enc_fire;
  logic                  mask_fire;
  logic [MEM_BW-1:0]     decoded;
  logic [IDX_W-1:0]      idx;

  // Number of bytes the held mask needs from the buffer
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop = pop + POP_W'(mask_q[i]);
    end
  end

  // Handshakes; clear blocks every transfer in its cycle
  always_comb begin
    dec_fire      = !clear && mask_full && (count_q >= CNT_W'(pop)) &&
                    (!dense_valid || dense_ready);
    encoded_ready = !clear && (count_q <= CNT_W'(LANES));
    masks_ready   = !clear && (!mask_full || dec_fire);
    enc_fire      = encoded_valid && encoded_ready;
    mask_fire     = masks_valid && masks_ready;
  end

  // Scatter buffered bytes into the lanes flagged by the mask, in lane order
  always_comb begin
    decoded = '0;
    idx     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mask_q[i]) begin
        decoded[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[idx];
        idx = idx + IDX_W'(1);
      end
    end
  end

  // Next buffer image: drop consumed bytes from the front, append a pushed word
  always_comb begin
    pop_used = dec_fire ? pop : '0;
    rem      = count_q - CNT_W'(pop_used);
    for (int unsigned j = 0; j < BUF_BYTES; j++) begin
      if ((j + 32'(pop_used)) < BUF_BYTES) begin
        buf_d[j] = buf_q[IDX_W'(j + 32'(pop_used))];
      end else begin
        buf_d[j] = '0;
      end
    end
    if (enc_fire) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        buf_d[IDX_W'(32'(rem) + k)] = encoded_input[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    count_d = rem + (enc_fire ? CNT_W'(LANES) : CNT_W'(0));
  end

  // Byte storage carries no reset; only count_q qualifies its contents
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Control state, held mask and dense output register
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      count_q     <= '0;
      mask_q      <= '0;
      mask_full   <= 1'b0;
      dense_out   <= '0;
      dense_valid <= 1'b0;
    end else if (clear) begin
      count_q     <= '0;
      mask_full   <= 1'b0;
      dense_valid <= 1'b0;
    end else begin
      count_q <= count_d;
      if (mask_fire) begin
        mask_q    <= masks_input;
        mask_full <= 1'b1;
      end else if (dec_fire) begin
        mask_full <= 1'b0;
      end
      if (dec_fire) begin
        dense_out   <= decoded;
        dense_valid <= 1'b1;
      end else if (dense_ready) begin
        dense_valid <= 1'b0;
      end
    end
  end

`ifdef SPARSE_DEC_STATS_EN
  logic [32:0] zc_sum;

  // Candidate count of inserted zeros, one bit wider to detect overflow
  always_comb begin
    zc_sum = {1'b0, zero_count} + 33'(POP_W'(LANES) - pop);
  end

  // Saturating count of zero lanes emitted since reset or clear
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      zero_count <= '0;
    end else if (clear) begin
      zero_count <= '0;
    end else if (dec_fire) begin
      zero_count <= zc_sum[32] ? 32'hFFFF_FFFF : zc_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_sparse_act_decoder.sv
// tb_sparse_act_decoder: directed and randomized checks of sparse_act_decoder
// against a queue-based reference (masks and bytes consumed in arrival order).

module tb_sparse_act_decoder;

  localparam int unsigned LANES  = 16;
  localparam int unsigned MEM_BW = 128;

  logic              clk = 1'b0;
  logic              arst_n_in;
  logic              clear;
  logic [LANES-1:0]  masks_input;
  logic              masks_valid;
  logic              masks_ready;
  logic [MEM_BW-1:0] encoded_input;
  logic              encoded_valid;
  logic              encoded_ready;
  logic [MEM_BW-1:0] dense_out;
  logic              dense_valid;
  logic              dense_ready;
`ifdef SPARSE_DEC_STATS_EN
  logic [31:0]       zero_count;
`endif

  always #5 clk = ~clk;

  sparse_act_decoder dut (
    .clk           (clk),
    .arst_n_in     (arst_n_in),
    .clear         (clear),
    .masks_input   (masks_input),
    .masks_valid   (masks_valid),
    .masks_ready   (masks_ready),
    .encoded_input (encoded_input),
    .encoded_valid (encoded_valid),
    .encoded_ready (encoded_ready),
    .dense_out     (dense_out),
    .dense_valid   (dense_valid),
    .dense_ready   (dense_ready)
`ifdef SPARSE_DEC_STATS_EN
    ,
    .zero_count    (zero_count)
`endif
  );

  int          vec_count = 0;
  int          err_count = 0;
  int          cyc = 0;
  int          last_m_cyc = 0;
  bit          rand_mode = 1'b0;
  logic        ready_force = 1'b1;
  logic [15:0]  msrc[$];
  logic [127:0] esrc[$];
  logic [15:0]  mq[$];
  logic [7:0]   bq[$];
  logic [127:0] got[$];
  bit           m_hs = 1'b0;
  bit           e_hs = 1'b0;
  bit           stall_prev = 1'b0;
  logic [127:0] prev_out;
  logic [127:0] exp_w;
  logic [15:0]  cur_m;
  bit           short_f;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] make_word(input logic [7:0] start);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = start + 8'(k);
    return w;
  endfunction

  function automatic logic [127:0] got_at(input int i);
    if (got.size() > i) return got[i];
    return 'x;
  endfunction

  always @(posedge clk) cyc++;

  // Mask source: presents queued masks, retires one per observed handshake
  initial begin
    masks_valid = 1'b0;
    masks_input = '0;
    forever begin
      @(posedge clk); #1;
      if (m_hs && msrc.size() > 0) msrc.delete(0);
      if (msrc.size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
        masks_valid = 1'b1;
        masks_input = msrc[0];
      end else begin
        masks_valid = 1'b0;
      end
    end
  end

  // Encoded word source
  initial begin
    encoded_valid = 1'b0;
    encoded_input = '0;
    forever begin
      @(posedge clk); #1;
      if (e_hs && esrc.size() > 0) esrc.delete(0);
      if (esrc.size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
        encoded_valid = 1'b1;
        encoded_input = esrc[0];
      end else begin
        encoded_valid = 1'b0;
      end
    end
  end

  // Downstream ready
  initial begin
    dense_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      dense_ready = rand_mode ? 1'($urandom_range(1)) : ready_force;
    end
  end

  // Reference model and compare: every delivered word must equal the next mask
  // filled with the next bytes of the encoded stream, in order
  always @(negedge clk) begin
    if (!arst_n_in) begin
      m_hs = 1'b0; e_hs = 1'b0; stall_prev = 1'b0;
      mq.delete(); bq.delete();
    end else if (clear) begin
      m_hs = 1'b0; e_hs = 1'b0; stall_prev = 1'b0;
      mq.delete(); bq.delete();
    end else begin
      m_hs = masks_valid && masks_ready;
      e_hs = encoded_valid && encoded_ready;
      if (stall_prev) begin
        chk("stall_valid", 128'(dense_valid), 128'(1));
        chk("stall_data", dense_out, prev_out);
      end
      if (dense_valid && dense_ready) begin
        exp_w = '0;
        short_f = 1'b0;
        if (mq.size() == 0) short_f = 1'b1;
        else begin
          cur_m = mq.pop_front();
          for (int i = 0; i < 16; i++) begin
            if (cur_m[i]) begin
              if (bq.size() == 0) short_f = 1'b1;
              else exp_w[i*8 +: 8] = bq.pop_front();
            end
          end
        end
        vec_count++;
        if (short_f) begin
          err_count++;
          $display("FAIL dense_unexpected: got %h with no matching mask/bytes in model", dense_out);
        end else if (dense_out !== exp_w) begin
          err_count++;
          $display("FAIL dense_word: got %h expected %h", dense_out, exp_w);
        end
        got.push_back(dense_out);
      end
      if (m_hs) begin
        mq.push_back(masks_input);
        last_m_cyc = cyc;
      end
      if (e_hs) for (int k = 0; k < 16; k++) bq.push_back(encoded_input[k*8 +: 8]);
      stall_prev = dense_valid && !dense_ready;
      prev_out   = dense_out;
    end
  end

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    vec_count++;
    if (got.size() < n) begin
      err_count++;
      $display("FAIL %s: timeout with %0d words, expected %0d", name, got.size(), n);
    end
  endtask

  task automatic wait_dv(input string name);
    int k = 0;
    while (!dense_valid && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, 128'(dense_valid), 128'(1));
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    msrc.delete(); esrc.delete();
    @(negedge clk); #1;
    chk("clear_enc_ready", 128'(encoded_ready), 128'(0));
    chk("clear_mask_ready", 128'(masks_ready), 128'(0));
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk); #1;
    chk("post_clear_valid", 128'(dense_valid), 128'(0));
    chk("post_clear_mready", 128'(masks_ready), 128'(1));
    chk("post_clear_eready", 128'(encoded_ready), 128'(1));
`ifdef SPARSE_DEC_STATS_EN
    chk("post_clear_zc", 128'(zero_count), 128'(0));
`endif
    got.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rand;
    int need;
    logic [15:0] rm;
    logic [127:0] w;
    arst_n_in = 1'b1;
    clear = 1'b0;
    #2 arst_n_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 128'(dense_valid), 128'(0));
    chk("rst_data", dense_out, 128'(0));
    chk("rst_mready", 128'(masks_ready), 128'(1));
    chk("rst_eready", 128'(encoded_ready), 128'(1));
`ifdef SPARSE_DEC_STATS_EN
    chk("rst_zc", 128'(zero_count), 128'(0));
`endif
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    repeat (2) @(negedge clk);

    // Full mask, bytes 1..16, one-cycle decode latency
    got.delete();
    msrc.push_back(16'hFFFF);
    esrc.push_back(make_word(8'h01));
    wait_dv("t2_valid");
    chk("t2_latency", 128'(cyc - last_m_cyc), 128'(2));
    wait_got(1, 50, "t2_wait");
    chk("t2_word", got_at(0), 128'h100F0E0D0C0B0A09_0807060504030201);

    // Empty mask needs no bytes; following full mask sees untouched buffer
    do_clear();
    msrc.push_back(16'h0000);
    wait_got(1, 50, "t3_wait");
    chk("t3_zero_word", got_at(0), 128'h0);
    msrc.push_back(16'hFFFF);
    esrc.push_back(make_word(8'h21));
    wait_got(2, 50, "t3b_wait");
    chk("t3_full_word", got_at(1), make_word(8'h21));

    // Encoded words straddling mask boundaries
    do_clear();
    msrc.push_back(16'h00FF);
    msrc.push_back(16'hFF00);
    msrc.push_back(16'h0F0F);
    esrc.push_back(make_word(8'h01));
    wait_got(2, 50, "t4_wait");
    chk("t4_word0", got_at(0), 128'h0000000000000000_0807060504030201);
    chk("t4_word1", got_at(1), 128'h100F0E0D0C0B0A09_0000000000000000);
    repeat (6) @(negedge clk);
    #1;
    chk("t4_third_waits", 128'(got.size()), 128'(2));
    chk("t4_third_not_valid", 128'(dense_valid), 128'(0));
    esrc.push_back(make_word(8'h11));
    wait_got(3, 50, "t4b_wait");
    chk("t4_word2", got_at(2), 128'h00000000_18171615_00000000_14131211);

    // Backpressure: output held, mask and encoded inputs throttled
    do_clear();
    ready_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      msrc.push_back(16'hFFFF);
      esrc.push_back({$urandom, $urandom, $urandom, $urandom});
    end
    wait_dv("t5_valid");
    repeat (6) @(negedge clk);
    #1;
    chk("t5_hold_valid", 128'(dense_valid), 128'(1));
    chk("t5_mask_blocked", 128'(masks_ready), 128'(0));
    chk("t5_enc_blocked", 128'(encoded_ready), 128'(0));
    ready_force = 1'b1;
    wait_got(4, 100, "t5_drain");

    // Clear with buffered bytes and a pending mask
    do_clear();
    msrc.push_back(16'h003F);
    esrc.push_back(make_word(8'h31));
    wait_got(1, 50, "t6_wait");
    chk("t6_partial", got_at(0), 128'h0000000000000000_0000363534333231);
    msrc.push_back(16'hFFFF);
    repeat (5) @(negedge clk);
    #1;
    chk("t6_pending_valid", 128'(dense_valid), 128'(0));
    chk("t6_pending_mready", 128'(masks_ready), 128'(0));
    do_clear();
    msrc.push_back(16'h0001);
    esrc.push_back(make_word(8'hAA));
    wait_got(1, 50, "t6b_wait");
    chk("t6_fresh", got_at(0), 128'h00000000000000000000000000000AA);

    // Asynchronous reset mid-operation drops everything immediately
    do_clear();
    ready_force = 1'b0;
    msrc.push_back(16'h0001);
    esrc.push_back(make_word(8'h41));
    wait_dv("t7_valid");
    @(posedge clk); #3;
    arst_n_in = 1'b0;
    #1;
    chk("t7_async_valid", 128'(dense_valid), 128'(0));
    chk("t7_async_data", dense_out, 128'h0);
    msrc.delete(); esrc.delete();
    ready_force = 1'b1;
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    got.delete();
    msrc.push_back(16'h0001);
    esrc.push_back(make_word(8'h77));
    wait_got(1, 50, "t7_wait");
    chk("t7_after_reset", got_at(0), 128'h77);

`ifdef SPARSE_DEC_STATS_EN
    // Zero statistics
    do_clear();
    msrc.push_back(16'h0001);
    msrc.push_back(16'h0000);
    msrc.push_back(16'hFFFF);
    esrc.push_back(make_word(8'h01));
    esrc.push_back(make_word(8'h11));
    wait_got(3, 50, "t8_wait");
    repeat (2) @(negedge clk);
    #1;
    chk("t8_zero_count", 128'(zero_count), 128'(31));
`endif

    // Randomized traffic with random valids and downstream stalls
    do_clear();
    n_rand = 200;
    need = 0;
    for (int i = 0; i < n_rand; i++) begin
      case ($urandom_range(5))
        0:       rm = 16'h0000;
        1:       rm = 16'hFFFF;
        default: rm = 16'($urandom);
      endcase
      msrc.push_back(rm);
      need += $countones(rm);
    end
    for (int i = 0; i < (need + 15) / 16; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      esrc.push_back(w);
    end
    rand_mode = 1'b1;
    wait_got(n_rand, 20000, "rand_drain");
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rand_masks_left", 128'(mq.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
